// File: rtl/systolic_pkg.sv
// Shared defaults and row type for the systolic array result path.
package systolic_pkg;

    localparam int unsigned DEF_SYSTOLIC_WIDTH = 4;
    localparam int unsigned DEF_SUM_WIDTH      = 16;
    localparam int unsigned DEF_FIFO_DEPTH     = 8;
    localparam int unsigned DEF_ROW_CNT_W      = 8;

    typedef logic [DEF_SYSTOLIC_WIDTH*DEF_SUM_WIDTH-1:0] row_t;

endpackage

// File: rtl/drain_fifo.sv
// Synchronous row FIFO with registered storage, occupancy count and synchronous flush.
module drain_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           wr_en,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           rd_en,
    output logic [WIDTH-1:0]               rd_data,
    output logic                           rd_valid,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             rd;

    assign full = (count_q == CW'(DEPTH));
    assign rd   = rd_en && (count_q != '0);

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (wr_en && !rd) begin
                count_q <= count_q + CW'(1);
            end else if (rd && !wr_en) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = (count_q != '0);
    assign count    = count_q;

    a_no_write_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) !(wr_en && full && !rd_en && !clear)
    );

endmodule

// File: rtl/systolic_drain.sv
// De-skews per-column partial sums from the systolic array into whole rows, buffers them
// and streams them out with tile framing. Expects SYSTOLIC_WIDTH >= 2.
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int unsigned SYSTOLIC_WIDTH = DEF_SYSTOLIC_WIDTH,
    parameter int unsigned SUM_WIDTH      = DEF_SUM_WIDTH,
    parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int unsigned ROW_CNT_W      = DEF_ROW_CNT_W
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clear,
    input  logic [SYSTOLIC_WIDTH*SUM_WIDTH-1:0]  sum_in,
    input  logic                                 sum_valid,
    output logic                                 in_ready,
    input  logic [ROW_CNT_W-1:0]                 tile_rows,
    output logic [SYSTOLIC_WIDTH*SUM_WIDTH-1:0]  out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 out_last,
    output logic                                 overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      level
);

    localparam int unsigned ROW_W = SYSTOLIC_WIDTH * SUM_WIDTH;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PIPE  = SYSTOLIC_WIDTH - 1;

    logic [PIPE-1:0]      valid_q;
    logic [ROW_W-1:0]     aligned_row;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic [LVL_W:0]       inflight;
    logic [LVL_W:0]       occupancy;
    logic [ROW_CNT_W-1:0] row_cnt_q;
    logic [ROW_CNT_W-1:0] last_idx;
    logic                 overflow_q;

    assign accept = sum_valid && in_ready && !clear;
    assign push   = valid_q[PIPE-1];
    assign pop    = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (clear) begin
            valid_q <= '0;
        end else begin
            valid_q <= (valid_q << 1) | PIPE'(accept);
        end
    end

    // Lane j arrives j cycles late; delay it so every lane lines up with lane N-1.
    for (genvar j = 0; j < SYSTOLIC_WIDTH; j++) begin : g_lane
        if (j == SYSTOLIC_WIDTH - 1) begin : g_direct
            assign aligned_row[j*SUM_WIDTH +: SUM_WIDTH] = sum_in[j*SUM_WIDTH +: SUM_WIDTH];
        end else begin : g_delay
            localparam int unsigned DLY = SYSTOLIC_WIDTH - 1 - j;
            logic [SUM_WIDTH-1:0] sr_q [DLY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < int'(DLY); k++) sr_q[k] <= '0;
                end else begin
                    sr_q[0] <= sum_in[j*SUM_WIDTH +: SUM_WIDTH];
                    for (int k = 1; k < int'(DLY); k++) sr_q[k] <= sr_q[k-1];
                end
            end

            assign aligned_row[j*SUM_WIDTH +: SUM_WIDTH] = sr_q[DLY-1];
        end
    end

    always_comb begin
        inflight = '0;
        for (int k = 0; k < int'(PIPE); k++) begin
            inflight = inflight + (LVL_W+1)'(valid_q[k]);
        end
    end

    // Rows already in the de-skew pipe hold a FIFO slot, so credit never oversubscribes.
    assign occupancy = {1'b0, level} + inflight;
    assign in_ready  = (occupancy < (LVL_W+1)'(FIFO_DEPTH));

    drain_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .wr_en    (push),
        .wr_data  (aligned_row),
        .rd_en    (pop),
        .rd_data  (out_data),
        .rd_valid (out_valid),
        .count    (level)
    );

    assign last_idx = (tile_rows == '0) ? '0 : tile_rows - ROW_CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt_q <= '0;
        end else if (clear) begin
            row_cnt_q <= '0;
        end else if (pop) begin
            row_cnt_q <= (row_cnt_q == last_idx) ? '0 : row_cnt_q + ROW_CNT_W'(1);
        end
    end

    assign out_last = out_valid && (row_cnt_q == last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (clear) begin
            overflow_q <= 1'b0;
        end else if (sum_valid && !in_ready) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;

endmodule
